// File: rtl/muldiv_unit_e.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with sign fix-up at completion.
module muldiv_unit_e #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MulDivStartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic            FlushE,
  output logic            MulDivBusyE,
  output logic            MulDivDoneE,
  output logic [XLEN-1:0] MulDivResultE
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode straight from the EX-stage inputs, used only on the accepting cycle.
  logic            is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign is_div   = MulDivOpE[2];
  assign a_signed = (MulDivOpE == 3'b001) | (MulDivOpE == 3'b010) |
                    (MulDivOpE == 3'b100) | (MulDivOpE == 3'b110);
  assign b_signed = (MulDivOpE == 3'b001) | (MulDivOpE == 3'b100) | (MulDivOpE == 3'b110);
  assign a_neg    = a_signed & SrcAE[XLEN-1];
  assign b_neg    = b_signed & WriteDataE[XLEN-1];
  assign a_mag    = a_neg ? -SrcAE : SrcAE;
  assign b_mag    = b_neg ? -WriteDataE : WriteDataE;
  assign div_zero = (WriteDataE == '0);
  assign div_ovf  = ~MulDivOpE[0] & (SrcAE == MIN_NEG) & (WriteDataE == '1);
  assign special  = is_div & (div_zero | div_ovf);
  assign special_res = div_zero ? (MulDivOpE[1] ? SrcAE : '1)
                                : (MulDivOpE[1] ? '0 : MIN_NEG);

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_cand, div_diff;
  logic              q_bit;
  logic [2*XLEN-1:0] step, prod;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res, final_res;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_cand = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_cand - {1'b0, opnd_q};
  assign q_bit    = ~div_diff[XLEN];
  assign step     = op_q[2]
                  ? {(q_bit ? div_diff[XLEN-1:0] : div_cand[XLEN-1:0]), acc_q[XLEN-2:0], q_bit}
                  : {mul_sum, acc_q[XLEN-1:1]};

  assign prod      = neg_q ? -step : step;
  assign mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign quo       = step[XLEN-1:0];
  assign rem       = step[2*XLEN-1:XLEN];
  assign div_res   = op_q[1] ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);
  assign final_res = op_q[2] ? div_res : mul_res;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    neg_d       = neg_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    result_d    = result_q;
    MulDivBusyE = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MulDivStartE && !FlushE) begin
          MulDivBusyE = 1'b1;
          op_d        = MulDivOpE;
          neg_d       = (is_div && MulDivOpE[1]) ? a_neg : (a_neg ^ b_neg);
          cnt_d       = '0;
          if (special) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else begin
            state_d = S_BUSY;
            opnd_d  = is_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          end
        end
      end
      S_BUSY: begin
        MulDivBusyE = 1'b1;
        acc_d       = step;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d  = S_DONE;
          result_d = final_res;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A kill discards the in-flight op and leaves the previous result visible.
    if (FlushE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
    if (reset) MulDivBusyE = 1'b0;
  end

  // NOTE: non-blocking assignments for all state; reset also clears the operand/accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign MulDivDoneE   = ~reset & (state_q == S_DONE);
  assign MulDivResultE = result_q;

endmodule
